// File: rtl/vend_ctrl.sv
// Vending controller: collects 5/10/25-cent coins, vends one of two items,
// and returns remaining credit as a train of 5-cent change pulses.
module vend_ctrl #(
    parameter int unsigned PRICE0     = 15,
    parameter int unsigned PRICE1     = 25,
    parameter int unsigned MAX_CREDIT = 95
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin_valid,
    input  logic [4:0] coin,
    output logic       coin_ready,
    output logic       coin_reject,
    input  logic       sel_valid,
    input  logic       sel,
    input  logic       cancel,
    output logic       vend_req,
    output logic       vend_item,
    input  logic       vend_done,
    output logic       change_pulse,
    output logic [6:0] credit,
    output logic       busy
);

    localparam int unsigned CW   = 7;
    localparam int unsigned SW   = 8;
    localparam int unsigned STEP = 5;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        VEND    = 2'd1,
        CHANGE  = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] credit_n;
    logic          vend_req_n, vend_item_n, change_pulse_n, coin_reject_n;

    logic          coin_take;
    logic          coin_legal;
    logic          coin_ok;
    logic [SW-1:0] coin_sum;
    logic [CW-1:0] credit_plus;
    logic [CW-1:0] price;

    // Handshake and status decode from state; both forced low during reset
    assign coin_ready = !rst && (state == COLLECT);
    assign busy       = !rst && (state != COLLECT);

    // Coin acceptance and selected price
    always_comb begin
        coin_take   = coin_valid && coin_ready;
        coin_legal  = (coin == 5'd5) || (coin == 5'd10) || (coin == 5'd25);
        coin_sum    = SW'(credit) + SW'(coin);
        coin_ok     = coin_legal && (coin_sum <= SW'(MAX_CREDIT));
        credit_plus = (coin_take && coin_ok) ? coin_sum[CW-1:0] : credit;
        price       = sel ? CW'(PRICE1) : CW'(PRICE0);
    end

    // Next-state and registered-output logic
    always_comb begin
        state_n        = state;
        credit_n       = credit;
        vend_req_n     = vend_req;
        vend_item_n    = vend_item;
        change_pulse_n = 1'b0;
        coin_reject_n  = coin_take && !coin_ok;

        case (state)
            COLLECT: begin
                credit_n = credit_plus;
                if (cancel && (credit != '0)) begin
                    state_n        = CHANGE;
                    change_pulse_n = 1'b1;
                end else if (sel_valid && (credit >= price)) begin
                    credit_n    = credit_plus - price;
                    state_n     = VEND;
                    vend_req_n  = 1'b1;
                    vend_item_n = sel;
                end
            end
            VEND: begin
                if (vend_done) begin
                    vend_req_n = 1'b0;
                    if (credit != '0) begin
                        state_n        = CHANGE;
                        change_pulse_n = 1'b1;
                    end else begin
                        state_n = COLLECT;
                    end
                end
            end
            CHANGE: begin
                // Pulse stays high while credit remains after this decrement
                if (credit > CW'(STEP)) begin
                    credit_n       = credit - CW'(STEP);
                    change_pulse_n = 1'b1;
                end else begin
                    credit_n = '0;
                    state_n  = COLLECT;
                end
            end
            default: begin
                state_n  = COLLECT;
                credit_n = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= COLLECT;
            credit       <= '0;
            vend_req     <= 1'b0;
            vend_item    <= 1'b0;
            change_pulse <= 1'b0;
            coin_reject  <= 1'b0;
        end else begin
            state        <= state_n;
            credit       <= credit_n;
            vend_req     <= vend_req_n;
            vend_item    <= vend_item_n;
            change_pulse <= change_pulse_n;
            coin_reject  <= coin_reject_n;
        end
    end

endmodule

// File: tb/tb_vend_ctrl.sv
// Self-checking bench for vend_ctrl: directed scenarios plus a randomized
// run against a transaction-level model of credit, vending and refunds.
module tb_vend_ctrl;

    localparam int P0   = 15;
    localparam int P1   = 25;
    localparam int MAXC = 95;

    logic       clk = 1'b0;
    logic       rst;
    logic       coin_valid;
    logic [4:0] coin;
    logic       coin_ready;
    logic       coin_reject;
    logic       sel_valid;
    logic       sel;
    logic       cancel;
    logic       vend_req;
    logic       vend_item;
    logic       vend_done;
    logic       change_pulse;
    logic [6:0] credit;
    logic       busy;

    int errors = 0;
    int checks = 0;

    // Reference model: money held, whether a vend is outstanding, whether
    // credit is being refunded, last vended item, last coin rejected.
    int m_credit = 0;
    bit m_vend   = 0;
    bit m_refund = 0;
    bit m_item   = 0;
    bit m_reject = 0;

    vend_ctrl #(.PRICE0(P0), .PRICE1(P1), .MAX_CREDIT(MAXC)) dut (
        .clk          (clk),
        .rst          (rst),
        .coin_valid   (coin_valid),
        .coin         (coin),
        .coin_ready   (coin_ready),
        .coin_reject  (coin_reject),
        .sel_valid    (sel_valid),
        .sel          (sel),
        .cancel       (cancel),
        .vend_req     (vend_req),
        .vend_item    (vend_item),
        .vend_done    (vend_done),
        .change_pulse (change_pulse),
        .credit       (credit),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic drive(input bit cv, input int cn, input bit sv, input bit s,
                         input bit cc, input bit vd);
        coin_valid = cv;
        coin       = 5'(cn);
        sel_valid  = sv;
        sel        = s;
        cancel     = cc;
        vend_done  = vd;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0);
    endtask

    // Advance the model by one transaction using current inputs, then clock the DUT
    task automatic step();
        int add;
        int price;
        add      = 0;
        price    = sel ? P1 : P0;
        m_reject = 0;
        if (rst) begin
            m_credit = 0; m_vend = 0; m_refund = 0; m_item = 0;
        end else if (m_vend) begin
            if (vend_done) begin
                m_vend   = 0;
                m_refund = (m_credit > 0);
            end
        end else if (m_refund) begin
            m_credit = m_credit - 5;
            if (m_credit <= 0) begin
                m_credit = 0;
                m_refund = 0;
            end
        end else begin
            if (coin_valid) begin
                if ((coin inside {5'd5, 5'd10, 5'd25}) && (m_credit + int'(coin) <= MAXC))
                    add = int'(coin);
                else
                    m_reject = 1;
            end
            if (cancel && m_credit > 0) begin
                m_credit = m_credit + add;
                m_refund = 1;
            end else if (sel_valid && m_credit >= price) begin
                m_credit = m_credit + add - price;
                m_vend   = 1;
                m_item   = sel;
            end else begin
                m_credit = m_credit + add;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        step();
        step();
        checks++;
        if (credit !== 7'd0) begin
            errors++; $display("FAIL reset_credit: got %0d want 0", credit);
        end
        checks++;
        if ({vend_req, vend_item, change_pulse, coin_reject, coin_ready, busy} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: req=%b item=%b pulse=%b rej=%b ready=%b busy=%b want all 0",
                     vend_req, vend_item, change_pulse, coin_reject, coin_ready, busy);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (coin_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_release: ready=%b busy=%b want 1/0", coin_ready, busy);
        end
        step();
    endtask

    task automatic test_basic_vend();
        drive(1, 10, 0, 0, 0, 0); step();
        checks++;
        if (credit !== 7'd10) begin errors++; $display("FAIL basic_credit10: got %0d want 10", credit); end
        drive(1, 5, 0, 0, 0, 0); step();
        checks++;
        if (credit !== 7'd15) begin errors++; $display("FAIL basic_credit15: got %0d want 15", credit); end
        drive(0, 0, 1, 0, 0, 0); step();
        checks++;
        if ({vend_req, vend_item, busy, coin_ready} !== 4'b1010 || credit !== 7'd0) begin
            errors++;
            $display("FAIL basic_vend: req=%b item=%b busy=%b ready=%b credit=%0d want 1/0/1/0 credit 0",
                     vend_req, vend_item, busy, coin_ready, credit);
        end
        idle(); step(); step();
        checks++;
        if (vend_req !== 1'b1) begin errors++; $display("FAIL basic_hold: vend_req=%b want 1", vend_req); end
        drive(0, 0, 0, 0, 0, 1); step();
        checks++;
        if ({vend_req, busy, change_pulse} !== 3'b000 || credit !== 7'd0) begin
            errors++;
            $display("FAIL basic_done: req=%b busy=%b pulse=%b credit=%0d want 0/0/0 credit 0",
                     vend_req, busy, change_pulse, credit);
        end
        idle(); step();
        checks++;
        if (change_pulse !== 1'b0) begin errors++; $display("FAIL basic_nochange: pulse=%b want 0", change_pulse); end
    endtask

    task automatic test_change();
        drive(1, 25, 0, 0, 0, 0); step();
        drive(1, 10, 0, 0, 0, 0); step();
        checks++;
        if (credit !== 7'd35) begin errors++; $display("FAIL change_credit35: got %0d want 35", credit); end
        drive(0, 0, 1, 1, 0, 0); step();
        checks++;
        if (vend_req !== 1'b1 || vend_item !== 1'b1 || credit !== 7'd10) begin
            errors++;
            $display("FAIL change_vend: req=%b item=%b credit=%0d want 1/1 credit 10", vend_req, vend_item, credit);
        end
        drive(0, 0, 0, 0, 0, 1); step();
        checks++;
        if (vend_req !== 1'b0 || change_pulse !== 1'b1 || credit !== 7'd10) begin
            errors++;
            $display("FAIL change_p1: req=%b pulse=%b credit=%0d want 0/1 credit 10", vend_req, change_pulse, credit);
        end
        idle(); step();
        checks++;
        if (change_pulse !== 1'b1 || credit !== 7'd5) begin
            errors++; $display("FAIL change_p2: pulse=%b credit=%0d want 1 credit 5", change_pulse, credit);
        end
        step();
        checks++;
        if (change_pulse !== 1'b0 || credit !== 7'd0 || busy !== 1'b0 || coin_ready !== 1'b1) begin
            errors++;
            $display("FAIL change_end: pulse=%b credit=%0d busy=%b ready=%b want 0 credit 0 busy 0 ready 1",
                     change_pulse, credit, busy, coin_ready);
        end
    endtask

    task automatic test_reject();
        int cnt;
        int seq[5] = '{25, 25, 25, 10, 5};
        foreach (seq[i]) begin
            drive(1, seq[i], 0, 0, 0, 0); step();
        end
        checks++;
        if (credit !== 7'd90) begin errors++; $display("FAIL reject_credit90: got %0d want 90", credit); end
        drive(1, 25, 0, 0, 0, 0); step();
        checks++;
        if (coin_reject !== 1'b1 || credit !== 7'd90) begin
            errors++; $display("FAIL reject_over: rej=%b credit=%0d want 1 credit 90", coin_reject, credit);
        end
        idle(); step();
        checks++;
        if (coin_reject !== 1'b0) begin errors++; $display("FAIL reject_oneshot: rej=%b want 0", coin_reject); end
        drive(1, 7, 0, 0, 0, 0); step();
        checks++;
        if (coin_reject !== 1'b1 || credit !== 7'd90) begin
            errors++; $display("FAIL reject_illegal: rej=%b credit=%0d want 1 credit 90", coin_reject, credit);
        end
        drive(1, 5, 0, 0, 0, 0); step();
        checks++;
        if (coin_reject !== 1'b0 || credit !== 7'd95) begin
            errors++; $display("FAIL reject_fill_max: rej=%b credit=%0d want 0 credit 95", coin_reject, credit);
        end
        drive(0, 0, 0, 0, 1, 0); step();
        idle();
        cnt = 0;
        for (int i = 0; i < 40 && change_pulse === 1'b1; i++) begin
            cnt++;
            step();
        end
        checks++;
        if (cnt != 19 || credit !== 7'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL reject_refund: pulses=%0d credit=%0d busy=%b want 19 credit 0 busy 0", cnt, credit, busy);
        end
    endtask

    task automatic test_sel_ignore();
        int cnt;
        bit saw_vend;
        drive(1, 10, 0, 0, 0, 0); step();
        drive(1, 10, 0, 0, 0, 0); step();
        drive(0, 0, 1, 1, 0, 0); step();
        checks++;
        if (credit !== 7'd20 || vend_req !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL selign_short: credit=%0d req=%b busy=%b want 20/0/0", credit, vend_req, busy);
        end
        drive(0, 0, 1, 0, 1, 0); step();
        idle();
        cnt = 0;
        saw_vend = 0;
        for (int i = 0; i < 20 && change_pulse === 1'b1; i++) begin
            cnt++;
            if (vend_req === 1'b1) saw_vend = 1;
            step();
        end
        checks++;
        if (cnt != 4 || saw_vend || credit !== 7'd0) begin
            errors++; $display("FAIL selign_cancel: pulses=%0d vend=%b credit=%0d want 4/0/0", cnt, saw_vend, credit);
        end
    endtask

    task automatic test_same_cycle();
        drive(1, 10, 0, 0, 0, 0); step();
        drive(1, 5, 1, 0, 0, 0); step();
        checks++;
        if (credit !== 7'd15 || vend_req !== 1'b0) begin
            errors++; $display("FAIL same_cycle: credit=%0d req=%b want 15/0", credit, vend_req);
        end
        drive(0, 0, 1, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0, 1); step();
        idle(); step();
    endtask

    task automatic test_reset_mid_vend();
        drive(1, 25, 0, 0, 0, 0); step();
        drive(0, 0, 1, 0, 0, 0); step();
        checks++;
        if (vend_req !== 1'b1 || credit !== 7'd10) begin
            errors++; $display("FAIL rstvend_setup: req=%b credit=%0d want 1 credit 10", vend_req, credit);
        end
        rst = 1'b1;
        idle(); step();
        checks++;
        if (vend_req !== 1'b0 || credit !== 7'd0 || change_pulse !== 1'b0) begin
            errors++; $display("FAIL rstvend_abort: req=%b credit=%0d pulse=%b want 0/0/0", vend_req, credit, change_pulse);
        end
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 1); step();
        checks++;
        if ({vend_req, change_pulse, busy, coin_ready} !== 4'b0001 || credit !== 7'd0) begin
            errors++;
            $display("FAIL rstvend_after: req=%b pulse=%b busy=%b ready=%b credit=%0d want 0/0/0/1 credit 0",
                     vend_req, change_pulse, busy, coin_ready, credit);
        end
        idle(); step();
    endtask

    task automatic test_random();
        int coin_tab[6] = '{5, 10, 25, 25, 7, 30};
        bit exp_busy;
        for (int n = 0; n < 800; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 1) == 1, coin_tab[$urandom_range(0, 5)],
                  $urandom_range(0, 9) < 3, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 99) < 6, $urandom_range(0, 9) < 3);
            step();
            exp_busy = !rst && (m_vend || m_refund);
            checks++;
            if (int'(credit) != m_credit) begin
                errors++; $display("FAIL rand_credit[%0d]: got %0d want %0d", n, credit, m_credit);
            end
            checks++;
            if ({vend_req, vend_item, change_pulse, coin_reject, busy, coin_ready} !==
                {m_vend, m_item, m_refund, m_reject, exp_busy, !rst && !exp_busy}) begin
                errors++;
                $display("FAIL rand_outputs[%0d]: req/item/pulse/rej/busy/ready got %b%b%b%b%b%b want %b%b%b%b%b%b",
                         n, vend_req, vend_item, change_pulse, coin_reject, busy, coin_ready,
                         m_vend, m_item, m_refund, m_reject, exp_busy, !rst && !exp_busy);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_basic_vend();
        test_change();
        test_reject();
        test_sel_ignore();
        test_same_cycle();
        test_reset_mid_vend();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
